// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants for the seven-segment receive path: active-low segment
// patterns for the hex digits, the all-off pattern, segment bit positions and
// the digit count, plus small helpers for decoding the active-low anode bus.
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Segment bit positions inside seg[6:0] = {g,f,e,d,c,b,a}.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low patterns, written {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    // Position of the set bit of a one-hot vector (don't-care otherwise).
    function automatic logic [1:0] onehot_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int b = 0; b < NUM_DIGITS; b++) begin
            if (v[b]) idx = 2'(b);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the hex-to-seven-segment table.
//   seg      in  7  active-low segment pattern {g,f,e,d,c,b,a}
//   nibble   out 4  decoded hex value (0 unless the pattern is a table hit)
//   is_blank out 1  all segments off
//   is_err   out 1  pattern is neither a hex digit nor blank
// -----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       is_blank,
    output logic       is_err
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        nibble   = 4'h0;
        is_blank = 1'b0;
        is_err   = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_HEX_A: nibble = 4'hA;
            SEG_HEX_B: nibble = 4'hB;
            SEG_HEX_C: nibble = 4'hC;
            SEG_HEX_D: nibble = 4'hD;
            SEG_HEX_E: nibble = 4'hE;
            SEG_HEX_F: nibble = 4'hF;
            SEG_BLANK: is_blank = 1'b1;
            default:   is_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// -----------------------------------------------------------------------------
// seg7_scan_capture
// Receive-side monitor for a multiplexed four-digit seven-segment bus. A
// {an, seg} sample that holds for STABLE_CYCLES+1 consecutive sampled edges
// with exactly one anode low is captured once, decoded, and stored for that
// digit. frame_valid pulses for one cycle when all four digits have been
// captured since the previous pulse.
//   clk          in   1  system clock, rising edge
//   reset        in   1  synchronous, active high
//   seg          in   7  active-low segments {g,f,e,d,c,b,a}
//   an           in   4  active-low digit anodes
//   digits       out 16  digit i at digits[4i+3:4i]
//   blank        out  4  digit i last captured as all-off
//   err          out  4  digit i last captured as an undecodable pattern
//   frame_valid  out  1  one-cycle frame-complete pulse
// -----------------------------------------------------------------------------
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4     // legal range 1..255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic [3:0]  err,
    output logic        frame_valid
);

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [3:0] r_an;
    logic [6:0] r_seg;
    logic [7:0] cnt;
    logic       taken;
    logic [3:0] seen;

    logic [3:0] dec_nibble;
    logic       dec_blank;
    logic       dec_err;

    logic       same;
    logic       sel_valid;
    logic [1:0] sel;
    logic       capture;
    logic [3:0] seen_next;
    logic       frame_done;

    seg7_pattern_decode u_decode (
        .seg      (r_seg),
        .nibble   (dec_nibble),
        .is_blank (dec_blank),
        .is_err   (dec_err)
    );

    // The capture edge must also see the pattern unchanged; otherwise a dwell
    // that ends exactly as cnt reaches CAP_CNT would be taken one sample short.
    assign same       = ({an, seg} == {r_an, r_seg});
    assign sel_valid  = is_onehot4(~r_an);
    assign sel        = onehot_index(~r_an);
    assign capture    = same && (cnt == CAP_CNT) && !taken && sel_valid;
    assign seen_next  = seen | (4'b0001 << sel);
    assign frame_done = capture && (seen_next == 4'hF);

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_an        <= 4'hF;
            r_seg       <= SEG_BLANK;
            cnt         <= 8'd0;
            taken       <= 1'b0;
            seen        <= 4'd0;
            digits      <= 16'd0;
            blank       <= 4'd0;
            err         <= 4'd0;
            frame_valid <= 1'b0;
        end else begin
            r_an  <= an;
            r_seg <= seg;

            if (!same) begin
                cnt   <= 8'd0;
                taken <= 1'b0;
            end else begin
                if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                if (capture) taken <= 1'b1;
            end

            frame_valid <= frame_done;

            if (capture) begin
                seen <= frame_done ? 4'd0 : seen_next;
                if (dec_blank) begin
                    blank[sel] <= 1'b1;
                    err[sel]   <= 1'b0;
                end else if (dec_err) begin
                    blank[sel] <= 1'b0;
                    err[sel]   <= 1'b1;
                end else begin
                    digits[{sel, 2'b00} +: 4] <= dec_nibble;
                    blank[sel]                <= 1'b0;
                    err[sel]                  <= 1'b0;
                end
            end
        end
    end

endmodule
